// File: rtl/inbuf_group_ctrl.sv
// Ping-pong bank sequencer for the input sample buffer: groups incoming samples
// into windows of 3 or 4, fills two banks alternately and hands full groups downstream.
module inbuf_group_ctrl #(
    parameter int ROWS = 8,
    parameter int RW   = 8
) (
    input  logic          clk,
    input  logic          rn,
    input  logic          start,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [1:0]    wr_slot,
    output logic [RW-1:0] wr_row,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          rd_bank,
    output logic [RW-1:0] rd_row,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    state_t     state;
    logic       mode3;
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic [1:0] last_slot;
    logic       group_done;
    logic       consume;

    assign last_slot  = mode3 ? 2'd2 : 2'd3;
    assign in_ready   = (state == S_RUN) && !full[wr_bank];
    assign wr_en      = in_valid && in_ready;
    assign out_valid  = full[rd_bank];
    assign consume    = out_valid && out_ready;
    assign group_done = wr_en && (wr_slot == last_slot);

    // A completing write and a consume always target different banks, so both apply.
    always_comb begin
        // NOTE: default assignment first, so no path leaves full_nxt unassigned (no latch).
        full_nxt = full;
        if (consume)    full_nxt[rd_bank] = 1'b0;
        if (group_done) full_nxt[wr_bank] = 1'b1;
    end

    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rn) begin
            state   <= S_IDLE;
            mode3   <= 1'b0;
            full    <= 2'b00;
            wr_bank <= 1'b0;
            wr_slot <= 2'd0;
            wr_row  <= '0;
            rd_bank <= 1'b0;
            rd_row  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        mode3   <= mode;
                        full    <= 2'b00;
                        wr_bank <= 1'b0;
                        wr_slot <= 2'd0;
                        wr_row  <= '0;
                        rd_bank <= 1'b0;
                        rd_row  <= '0;
                    end
                end
                S_RUN, S_FLUSH: begin
                    full <= full_nxt;
                    if (wr_en) begin
                        if (group_done) begin
                            wr_slot <= 2'd0;
                            wr_bank <= ~wr_bank;
                            wr_row  <= wr_row + ROW_ONE;
                        end else begin
                            wr_slot <= wr_slot + 2'd1;
                        end
                    end
                    if (consume) begin
                        rd_bank <= ~rd_bank;
                        rd_row  <= rd_row + ROW_ONE;
                    end
                    if (state == S_RUN && group_done && wr_row == LAST_ROW) begin
                        state <= S_FLUSH;
                    end
                    if (state == S_FLUSH && full_nxt == 2'b00) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inbuf_group_ctrl.sv
// Self-checking bench for inbuf_group_ctrl: directed frames plus randomized handshakes,
// compared every cycle against a sample/group counting reference model.
module tb_inbuf_group_ctrl;

    localparam int ROWS = 8;
    localparam int RW   = 8;

    logic          clk;
    logic          rn;
    logic          start;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic          wr_bank;
    logic [1:0]    wr_slot;
    logic [RW-1:0] wr_row;
    logic          out_valid;
    logic          out_ready;
    logic          rd_bank;
    logic [RW-1:0] rd_row;
    logic          busy;
    logic          done;

    inbuf_group_ctrl #(.ROWS(ROWS), .RW(RW)) dut (
        .clk       (clk),
        .rn        (rn),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_slot   (wr_slot),
        .wr_row    (wr_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_bank   (rd_bank),
        .rd_row    (rd_row),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int t0       = 0;

    // Reference model: phase 0 idle, 1 run, 2 flush, 3 done; k samples accepted,
    // c groups consumed, n group size. Everything else follows by arithmetic.
    int m_phase = 0;
    int m_k     = 0;
    int m_c     = 0;
    int m_n     = 4;

    logic [10:0] acc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [24:0] dut_vec();
        return {in_ready, wr_en, wr_bank, wr_slot, wr_row,
                out_valid, rd_bank, rd_row, busy, done};
    endfunction

    function automatic logic [24:0] exp_vec();
        int   g;
        logic ir;
        g  = m_k / m_n;
        ir = (m_phase == 1) && (g - m_c < 2);
        return {ir, ir && in_valid, 1'(g % 2), 2'(m_k % m_n), 8'(g),
                (g > m_c), 1'(m_c % 2), 8'(m_c),
                (m_phase == 1 || m_phase == 2), (m_phase == 3)};
    endfunction

    task automatic tick();
        int   g;
        logic e_wr, e_cons;
        @(negedge clk);
        check("cycle_vec", 32'(dut_vec()), 32'(exp_vec()));
        if (wr_en === 1'b1) acc_q.push_back({wr_bank, wr_row, wr_slot});
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        g      = m_k / m_n;
        e_wr   = (m_phase == 1) && (g - m_c < 2) && in_valid;
        e_cons = (g > m_c) && out_ready;
        if (!rn) begin
            m_phase = 0; m_k = 0; m_c = 0; m_n = 4;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_n = mode ? 3 : 4; m_k = 0; m_c = 0;
                end
                1, 2: begin
                    m_k += int'(e_wr);
                    m_c += int'(e_cons);
                    if (m_phase == 1 && m_k == ROWS * m_n) m_phase = 2;
                    else if (m_phase == 2 && m_c == ROWS) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_frame(input bit rnd_in, input bit rnd_out, input bit rnd_ctl);
        int base;
        base = done_cnt;
        for (int i = 0; i < 600 && done_cnt == base; i++) begin
            if (rnd_in)  in_valid  = 1'($urandom_range(0, 1));
            if (rnd_out) out_ready = 1'($urandom_range(0, 1));
            if (rnd_ctl) mode      = 1'($urandom_range(0, 1));
            tick();
        end
        if (done_cnt == base) check("frame_timeout", 32'(done_cnt), 32'(base + 1));
    endtask

    task automatic check_accepts(input int n);
        int g;
        check("n_accept", 32'(acc_q.size()), 32'(ROWS * n));
        for (int i = 0; i < acc_q.size(); i++) begin
            g = i / n;
            check("accept_addr", 32'(acc_q[i]), 32'({1'(g % 2), 8'(g), 2'(i % n)}));
        end
    endtask

    task automatic begin_frame(input logic m);
        acc_q.delete();
        mode  = m;
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int base;
        rn = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("reset_state", 32'(dut_vec()), 32'd0);
        rn = 1'b1;
        tick();

        // Mode 3, full throughput.
        in_valid = 1'b1; out_ready = 1'b1;
        begin_frame(1'b1);
        run_frame(1'b0, 1'b0, 1'b0);
        check("done_latency_n3", 32'(done_cyc - t0), 32'(ROWS * 3 + 2));
        check_accepts(3);

        // Mode 4, downstream stalled until both banks fill.
        in_valid = 1'b1; out_ready = 1'b0;
        begin_frame(1'b0);
        for (int i = 0; i < 8; i++) tick();
        check("both_full_stall", 32'({in_ready, out_valid}), 32'(2'b01));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_no_wr", 32'(wr_en), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("resume_point", 32'({in_ready, wr_bank, wr_slot, wr_row}), 32'({1'b1, 1'b0, 2'd0, 8'd2}));
        run_frame(1'b0, 1'b1, 1'b0);
        check_accepts(4);

        // Mode 3, consume on the cycle the second group completes.
        in_valid = 1'b1; out_ready = 1'b0;
        begin_frame(1'b1);
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("simul_complete", 32'({out_valid, rd_bank, rd_row, in_ready, wr_bank}),
              32'({1'b1, 1'b1, 8'd1, 1'b1, 1'b0}));
        out_ready = 1'b1;
        run_frame(1'b0, 1'b0, 1'b0);

        // Mode 4, random handshakes on both sides.
        base = done_cnt;
        begin_frame(1'b0);
        run_frame(1'b1, 1'b1, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("done_once", 32'(done_cnt - base), 32'd1);
        check_accepts(4);

        // Reset mid-frame, then a clean 3-slot frame.
        in_valid = 1'b1; out_ready = 1'b0;
        begin_frame(1'b0);
        mode = 1'b1;
        tick();
        rn = 1'b0;
        tick();
        rn = 1'b1;
        check("mid_reset", 32'(dut_vec()), 32'd0);
        in_valid = 1'b1; out_ready = 1'b0;
        begin_frame(1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("pre_reset_pt", 32'({wr_slot, out_valid, rd_bank, in_ready}), 32'({2'd2, 1'b1, 1'b0, 1'b1}));
        rn = 1'b0;
        tick();
        rn = 1'b1;
        check("mid_reset_run", 32'(dut_vec()), 32'd0);
        out_ready = 1'b1;
        begin_frame(1'b1);
        run_frame(1'b0, 1'b0, 1'b0);
        check("done_latency_rst", 32'(done_cyc - t0), 32'(ROWS * 3 + 2));
        check_accepts(3);

        // start held high and mode toggling during the frame are ignored.
        in_valid = 1'b1; out_ready = 1'b1;
        begin_frame(1'b0);
        start = 1'b1;
        run_frame(1'b0, 1'b0, 1'b1);
        check("done_to_idle", 32'({busy, done}), 32'd0);
        check_accepts(4);
        acc_q.delete();
        mode = 1'b1;
        t0   = cyc;
        tick();
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        run_frame(1'b0, 1'b0, 1'b0);
        check_accepts(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
